muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 136 +++++++++++++
 tb/tb_muldiv_unit.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers: one shift-add or
// restoring shift-subtract step per cycle, signed ops done on magnitudes.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             we_hi,
    input  logic             we_lo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    count;
    logic [2*WIDTH:0] acc, acc_step;
    logic [WIDTH-1:0] opnd;
    logic [1:0]       op_q;
    logic             neg_res, neg_rem;

    logic             a_neg, b_neg, last;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   mul_sum, div_shift, div_diff;
    logic             div_ge, div_zero;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0] quo, rem, quo_fix, rem_fix, res_hi, res_lo;

    assign a_neg = op[0] & a[WIDTH-1];
    assign b_neg = op[0] & b[WIDTH-1];
    assign mag_a = a_neg ? -a : a;
    assign mag_b = b_neg ? -b : b;
    assign last  = (state == RUN) && (count == CW'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (count == CW'(1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
    end

    // acc holds {0, upper, lower}: product/multiplier for MUL, remainder/quotient for DIV.
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : '0)};
        div_shift = acc[2*WIDTH-1:WIDTH-1];
        div_ge    = div_shift >= {1'b0, opnd};
        div_diff  = div_shift - {1'b0, opnd};
        if (op_q[1])
            acc_step = {1'b0, (div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                        acc[WIDTH-2:0], div_ge};
        else
            acc_step = {1'b0, mul_sum, acc[WIDTH-1:1]};
    end

    // Sign fix-up on the final step's result; divide by zero forces all-ones quotient.
    always_comb begin
        div_zero = (opnd == '0);
        prod     = acc_step[2*WIDTH-1:0];
        prod_fix = neg_res ? -prod : prod;
        quo      = acc_step[WIDTH-1:0];
        rem      = acc_step[2*WIDTH-1:WIDTH];
        quo_fix  = div_zero ? '1 : (neg_res ? -quo : quo);
        rem_fix  = neg_rem ? -rem : rem;
        if (op_q[1]) begin
            res_hi = rem_fix;
            res_lo = quo_fix;
        end else begin
            res_hi = prod_fix[2*WIDTH-1:WIDTH];
            res_lo = prod_fix[WIDTH-1:0];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count       <= '0;
            acc         <= '0;
            opnd        <= '0;
            op_q        <= '0;
            neg_res     <= 1'b0;
            neg_rem     <= 1'b0;
            done        <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (we_hi) hi <= wdata;
                if (we_lo) lo <= wdata;
                if (start) begin
                    acc         <= {{(WIDTH+1){1'b0}}, (op[1] ? mag_a : mag_b)};
                    opnd        <= op[1] ? mag_b : mag_a;
                    op_q        <= op;
                    neg_res     <= a_neg ^ b_neg;
                    neg_rem     <= a_neg;
                    count       <= CW'(WIDTH);
                    div_by_zero <= 1'b0;
                end
            end else begin
                acc   <= acc_step;
                count <= count - CW'(1);
                if (last) begin
                    hi   <= res_hi;
                    lo   <= res_lo;
                    done <= 1'b1;
                    if (op_q[1]) div_by_zero <= div_zero;
                end
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (WIDTH=32): directed scenarios plus
// randomized operations against a plain-arithmetic reference model.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset, start, we_hi, we_lo;
    logic [1:0]  op;
    logic [31:0] a, b, wdata;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    int checks = 0;
    int failures = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .we_hi(we_hi), .we_lo(we_lo), .wdata(wdata), .busy(busy), .done(done),
        .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    function automatic void model(input logic [1:0] o, input logic [31:0] x, y,
                                  output logic [31:0] eh, output logic [31:0] el,
                                  output logic ez);
        logic [63:0] p;
        longint sx, sy, q, r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ez = 1'b0;
        case (o)
            2'd0: p = {32'd0, x} * {32'd0, y};
            2'd1: p = sx * sy;
            default: begin
                if (y == 32'd0) begin
                    p  = {x, 32'hFFFF_FFFF};
                    ez = 1'b1;
                end else if (o == 2'd2) begin
                    p = {x % y, x / y};
                end else begin
                    q = sx / sy;
                    r = sx % sy;
                    p = {r[31:0], q[31:0]};
                end
            end
        endcase
        eh = p[63:32];
        el = p[31:0];
    endfunction

    // Issue one op; after acceptance the operand inputs are disturbed to prove they are latched.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, y, input bit zero_after,
                          output int lat, output int busy_cyc);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0;
        a  = zero_after ? 32'd0 : $urandom;
        b  = zero_after ? 32'd0 : $urandom;
        op = zero_after ? 2'd0 : 2'($urandom_range(0, 3));
        lat = 0;
        busy_cyc = 0;
        while (done !== 1'b1 && lat < 100) begin
            if (busy === 1'b1) busy_cyc++;
            @(posedge clk);
            lat++;
            #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; op = 2'd0; a = '0; b = '0;
        we_hi = 1'b0; we_lo = 1'b0; wdata = '0;
        #1;
        checks++;
        if ({busy, done, div_by_zero, hi, lo} !== 67'd0) begin
            failures++;
            $display("FAIL reset_state: got busy=%b done=%b dbz=%b hi=%h lo=%h expected all zero",
                     busy, done, div_by_zero, hi, lo);
        end
        @(posedge clk); @(posedge clk); #3;
        reset = 1'b0;
    endtask

    task automatic test_multu_max();
        int lat, bc;
        run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat, bc);
        checks++;
        if (lat !== 32) begin failures++; $display("FAIL multu_latency: got %0d expected 32", lat); end
        checks++;
        if (bc !== 32) begin failures++; $display("FAIL multu_busy_cycles: got %0d expected 32", bc); end
        checks++;
        if ({busy, hi, lo} !== {1'b0, 32'hFFFF_FFFE, 32'h0000_0001}) begin
            failures++;
            $display("FAIL multu_max: got busy=%b hi=%h lo=%h expected busy=0 hi=fffffffe lo=00000001", busy, hi, lo);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL done_one_cycle: got %b expected 0", done); end
    endtask

    task automatic test_mult_neg();
        int lat, bc;
        run_op(2'd1, 32'hFFFF_FFFD, 32'd7, 1'b1, lat, bc);
        checks++;
        if ({hi, lo} !== {32'hFFFF_FFFF, 32'hFFFF_FFEB}) begin
            failures++;
            $display("FAIL mult_neg: got hi=%h lo=%h expected hi=ffffffff lo=ffffffeb", hi, lo);
        end
    endtask

    task automatic test_div_signed();
        int lat, bc;
        run_op(2'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, lat, bc);
        checks++;
        if ({hi, lo} !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin
            failures++;
            $display("FAIL div_neg7_by_2: got hi=%h lo=%h expected hi=ffffffff lo=fffffffd", hi, lo);
        end
        run_op(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lat, bc);
        checks++;
        if ({hi, lo, div_by_zero} !== {32'd0, 32'h8000_0000, 1'b0}) begin
            failures++;
            $display("FAIL div_min_by_m1: got hi=%h lo=%h dbz=%b expected hi=0 lo=80000000 dbz=0",
                     hi, lo, div_by_zero);
        end
    endtask

    task automatic test_div_zero();
        int lat, bc;
        run_op(2'd2, 32'd5, 32'd0, 1'b0, lat, bc);
        checks++;
        if ({hi, lo, div_by_zero} !== {32'd5, 32'hFFFF_FFFF, 1'b1} || lat !== 32) begin
            failures++;
            $display("FAIL divu_by_zero: got hi=%h lo=%h dbz=%b lat=%0d expected hi=5 lo=ffffffff dbz=1 lat=32",
                     hi, lo, div_by_zero, lat);
        end
        @(negedge clk);
        start = 1'b1; op = 2'd2; a = 32'd9; b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if ({div_by_zero, busy} !== 2'b01) begin
            failures++;
            $display("FAIL dbz_clear_on_accept: got dbz=%b busy=%b expected dbz=0 busy=1", div_by_zero, busy);
        end
        lat = 0;
        while (done !== 1'b1 && lat < 100) begin @(posedge clk); lat++; #1; end
        checks++;
        if ({hi, lo, div_by_zero} !== {32'd0, 32'd3, 1'b0}) begin
            failures++;
            $display("FAIL divu_9_by_3: got hi=%h lo=%h dbz=%b expected hi=0 lo=3 dbz=0", hi, lo, div_by_zero);
        end
    endtask

    task automatic test_mthi_mtlo();
        logic [31:0] lo_before;
        int done_cnt;
        bit lo_moved;
        @(negedge clk);
        we_hi = 1'b1; wdata = 32'h1234;
        @(posedge clk); #1;
        we_hi = 1'b0;
        checks++;
        if (hi !== 32'h1234) begin failures++; $display("FAIL mthi: got %h expected 00001234", hi); end
        @(negedge clk);
        we_hi = 1'b1; we_lo = 1'b1; wdata = 32'h5A5A_0F0F;
        @(posedge clk); #1;
        we_hi = 1'b0; we_lo = 1'b0;
        checks++;
        if ({hi, lo} !== {32'h5A5A_0F0F, 32'h5A5A_0F0F}) begin
            failures++;
            $display("FAIL mthi_mtlo_both: got hi=%h lo=%h expected 5a5a0f0f both", hi, lo);
        end
        @(negedge clk);
        start = 1'b1; op = 2'd2; a = 32'd100; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        lo_before = lo;
        done_cnt = 0;
        lo_moved = 1'b0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk);
            start = (cyc == 5); we_lo = (cyc == 5); wdata = 32'hDEAD_BEEF;
            @(posedge clk); #1;
            start = 1'b0; we_lo = 1'b0;
            if (done === 1'b1) done_cnt++;
            if (cyc < 32 && lo !== lo_before) lo_moved = 1'b1;
        end
        checks++;
        if (lo_moved) begin failures++; $display("FAIL mtlo_in_run: got lo changed expected unchanged before result"); end
        checks++;
        if (done_cnt !== 1) begin failures++; $display("FAIL start_ignored_in_run: got %0d done pulses expected 1", done_cnt); end
        checks++;
        if ({hi, lo} !== {32'd2, 32'd14}) begin
            failures++;
            $display("FAIL divu_100_by_7: got hi=%h lo=%h expected hi=2 lo=e", hi, lo);
        end
    endtask

    task automatic test_start_with_write();
        int lat;
        @(negedge clk);
        start = 1'b1; op = 2'd0; a = 32'd3; b = 32'd4;
        we_hi = 1'b1; we_lo = 1'b1; wdata = 32'hAAAA;
        @(posedge clk); #1;
        start = 1'b0; we_hi = 1'b0; we_lo = 1'b0;
        checks++;
        if ({hi, lo, busy} !== {32'hAAAA, 32'hAAAA, 1'b1}) begin
            failures++;
            $display("FAIL start_and_write: got hi=%h lo=%h busy=%b expected aaaa aaaa 1", hi, lo, busy);
        end
        lat = 0;
        while (done !== 1'b1 && lat < 100) begin @(posedge clk); lat++; #1; end
        checks++;
        if ({hi, lo} !== {32'd0, 32'd12} || lat !== 32) begin
            failures++;
            $display("FAIL result_overwrites_write: got hi=%h lo=%h lat=%0d expected hi=0 lo=c lat=32", hi, lo, lat);
        end
    endtask

    task automatic test_reset_mid();
        int lat, bc, done_cnt;
        logic [31:0] eh, el;
        logic ez;
        @(negedge clk);
        start = 1'b1; op = 2'd0; a = 32'h0001_0003; b = 32'h0002_0005;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({busy, done, hi, lo} !== 66'd0) begin
            failures++;
            $display("FAIL async_reset_mid_run: got busy=%b done=%b hi=%h lo=%h expected all zero", busy, done, hi, lo);
        end
        @(posedge clk); #3;
        reset = 1'b0;
        done_cnt = 0;
        repeat (40) begin @(posedge clk); #1; if (done === 1'b1) done_cnt++; end
        checks++;
        if (done_cnt !== 0 || {hi, lo} !== 64'd0) begin
            failures++;
            $display("FAIL aborted_op_silent: got %0d done pulses hi=%h lo=%h expected 0 pulses and zero", done_cnt, hi, lo);
        end
        #3;
        reset = 1'b1;
        #4;
        reset = 1'b0;
        run_op(2'd0, 32'h0001_0003, 32'h0002_0005, 1'b0, lat, bc);
        model(2'd0, 32'h0001_0003, 32'h0002_0005, eh, el, ez);
        checks++;
        if ({hi, lo} !== {eh, el} || lat !== 32) begin
            failures++;
            $display("FAIL op_after_reset: got hi=%h lo=%h lat=%0d expected hi=%h lo=%h lat=32", hi, lo, lat, eh, el);
        end
    endtask

    task automatic test_back_to_back();
        int lat1, lat2, bc;
        logic [31:0] eh, el;
        logic ez;
        run_op(2'd1, 32'h8000_0000, 32'h8000_0000, 1'b0, lat1, bc);
        model(2'd1, 32'h8000_0000, 32'h8000_0000, eh, el, ez);
        checks++;
        if ({hi, lo} !== {eh, el}) begin
            failures++;
            $display("FAIL b2b_first: got hi=%h lo=%h expected hi=%h lo=%h", hi, lo, eh, el);
        end
        run_op(2'd3, 32'hFFFF_FF9C, 32'd0, 1'b0, lat2, bc);
        model(2'd3, 32'hFFFF_FF9C, 32'd0, eh, el, ez);
        checks++;
        if ({hi, lo, div_by_zero} !== {eh, el, ez} || lat2 !== 32 || bc !== 32) begin
            failures++;
            $display("FAIL b2b_second: got hi=%h lo=%h dbz=%b lat=%0d busy=%0d expected hi=%h lo=%h dbz=%b lat=32 busy=32",
                     hi, lo, div_by_zero, lat2, bc, eh, el, ez);
        end
    endtask

    task automatic test_random();
        int lat, bc;
        logic [1:0] o;
        logic [31:0] x, y, eh, el;
        logic ez;
        for (int i = 0; i < 60; i++) begin
            o = 2'($urandom_range(0, 3));
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 5))
                0: y = 32'd0;
                1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
                2: begin x = 32'($urandom_range(0, 200)); y = 32'($urandom_range(1, 20)); end
                3: y = {{24{y[7]}}, y[7:0]};
                default: ;
            endcase
            run_op(o, x, y, 1'b0, lat, bc);
            model(o, x, y, eh, el, ez);
            checks++;
            if ({hi, lo, div_by_zero} !== {eh, el, ez} || lat !== 32) begin
                failures++;
                $display("FAIL random_op%0d: op=%0d a=%h b=%h got hi=%h lo=%h dbz=%b lat=%0d expected hi=%h lo=%h dbz=%b lat=32",
                         i, o, x, y, hi, lo, div_by_zero, lat, eh, el, ez);
            end
        end
    endtask

    initial begin
        test_reset();
        test_multu_max();
        test_mult_neg();
        test_div_signed();
        test_div_zero();
        test_mthi_mtlo();
        test_start_with_write();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
